// File: rtl/mac_seq_ctrl.sv
// Sequencer for the SD4 MAC pipeline: issues operand fetches for one dot-product job,
// tracks in-flight ops and captures the final result. Optional stall counter: MAC_SEQ_STALL_CNT_EN.
module mac_seq_ctrl #(
   parameter int PIPE_DEPTH = 4,
   parameter int LEN_W      = 8,
   parameter int ADDR_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  vec_len,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              stall,
   output logic              busy,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              pipe_en,
   output logic              acc_clr,
   input  logic              res_sign_in,
   input  logic [10:0]       res_norm_in,
   input  logic [6:0]        res_exp_in,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_sign,
   output logic [10:0]       res_norm,
   output logic [6:0]        res_exp,
   output logic [15:0]       stall_cnt,
   output logic [1:0]        state_dbg
);

   // Handshake: res_valid/res_ready is a strict valid/ready pair. Once res_valid is high the
   // result fields are held unchanged until the edge where res_ready is also high; res_valid
   // drops in the following cycle and the fields keep their value until the next capture.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    idx_q;
   logic [ADDR_W-1:0]   base_q;
   logic [PIPE_DEPTH-1:0] vld_q;
   logic [PIPE_DEPTH-1:0] last_q;
   logic                res_sign_q;
   logic [10:0]         res_norm_q;
   logic [6:0]          res_exp_q;

   logic accept;
   logic issue;
   logic last_issue;
   logic final_last;
   logic capture;

   assign accept     = (state_q == S_IDLE) && start;
   assign issue      = (state_q == S_ISSUE) && !stall;
   assign last_issue = issue && (idx_q == (len_q - LEN_W'(1)));
   // Bit PIPE_DEPTH-1 of the shift register mirrors the final MAC stage.
   assign final_last = vld_q[PIPE_DEPTH-1] && last_q[PIPE_DEPTH-1];
   assign capture    = (state_q == S_DRAIN) && final_last;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (vec_len == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (last_issue) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (final_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      rd_en     = issue;
      acc_clr   = issue && (idx_q == '0);
      rd_addr   = '0;
      pipe_en   = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && !stall;
      res_valid = (state_q == S_DONE);
      state_dbg = state_q;
      if (state_q == S_ISSUE) begin
         rd_addr = base_q + ADDR_W'(idx_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         len_q      <= '0;
         idx_q      <= '0;
         base_q     <= '0;
         vld_q      <= '0;
         last_q     <= '0;
         res_sign_q <= 1'b0;
         res_norm_q <= '0;
         res_exp_q  <= '0;
      end else begin
         if (accept) begin
            len_q  <= vec_len;
            base_q <= base_addr;
            idx_q  <= '0;
            vld_q  <= '0;
            last_q <= '0;
            if (vec_len == '0) begin
               res_sign_q <= 1'b0;
               res_norm_q <= '0;
               res_exp_q  <= '0;
            end
         end
         if (issue) begin
            idx_q <= idx_q + LEN_W'(1);
         end
         if (pipe_en) begin
            vld_q[0]  <= issue;
            last_q[0] <= last_issue;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
               vld_q[i]  <= vld_q[i-1];
               last_q[i] <= last_q[i-1];
            end
         end
         // The final stage is sampled even when stalled: its contents are already complete.
         if (capture) begin
            res_sign_q <= res_sign_in;
            res_norm_q <= res_norm_in;
            res_exp_q  <= res_exp_in;
         end
      end
   end

   assign res_sign = res_sign_q;
   assign res_norm = res_norm_q;
   assign res_exp  = res_exp_q;

`ifdef MAC_SEQ_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else if (accept) begin
         stall_cnt_q <= '0;
      end else if (((state_q == S_ISSUE) || (state_q == S_DRAIN)) && stall
                   && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed jobs plus randomized jobs checked against
// a cycle-counting reference model of the job timeline.
module tb_mac_seq_ctrl;

   localparam int D = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  vec_len;
   logic [7:0]  base_addr;
   logic        stall;
   logic        busy;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic        pipe_en;
   logic        acc_clr;
   logic        res_sign_in;
   logic [10:0] res_norm_in;
   logic [6:0]  res_exp_in;
   logic        res_valid;
   logic        res_ready;
   logic        res_sign;
   logic [10:0] res_norm;
   logic [6:0]  res_exp;
   logic [15:0] stall_cnt;
   logic [1:0]  state_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_q[$];

   mac_seq_ctrl #(.PIPE_DEPTH(D), .LEN_W(8), .ADDR_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .base_addr(base_addr),
      .stall(stall), .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .pipe_en(pipe_en),
      .acc_clr(acc_clr), .res_sign_in(res_sign_in), .res_norm_in(res_norm_in),
      .res_exp_in(res_exp_in), .res_valid(res_valid), .res_ready(res_ready),
      .res_sign(res_sign), .res_norm(res_norm), .res_exp(res_exp),
      .stall_cnt(stall_cnt), .state_dbg(state_dbg)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_rd_en"}, rd_en, 0);
      check({tag, "_rd_addr"}, rd_addr, 0);
      check({tag, "_pipe_en"}, pipe_en, 0);
      check({tag, "_acc_clr"}, acc_clr, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_res"}, {res_sign, res_norm, res_exp}, 0);
      check({tag, "_stall_cnt"}, stall_cnt, 0);
      check({tag, "_state"}, state_dbg, 0);
   endtask

   task automatic drive_idle();
      start       = 1'b0;
      vec_len     = '0;
      base_addr   = '0;
      stall       = 1'b0;
      res_ready   = 1'b0;
      {res_sign_in, res_norm_in, res_exp_in} = '0;
   endtask

   // One job from start to completed handshake. Model: count non-stalled cycles;
   // the first len of them issue, and the cycle after the (len+D-1)th one holds the
   // last op in the final stage.
   task automatic run_job(input int len, input int base, input logic [31:0] stall_mask,
                          input int stall_pct, input int ready_dly, input bit poke_start);
      int          ns;
      int          c;
      int          n_stall;
      bit          st;
      bit          done;
      logic [18:0] cap;
      logic [15:0] exp_cnt;

      @(posedge clk); #1;
      start     = 1'b1;
      vec_len   = 8'(len);
      base_addr = 8'(base);
      stall     = 1'b0;
      res_ready = 1'b0;
      @(negedge clk);
      check("pre_start_busy", busy, 0);
      for (int k = 0; k < len; k++) exp_q.push_back(8'(base + k));

      ns = 0; c = 0; n_stall = 0; cap = '0;
      done = (len == 0);
      while (!done) begin
         @(posedge clk); #1;
         c++;
         start     = 1'b0;
         vec_len   = 8'($urandom);
         base_addr = 8'($urandom);
         st        = ((c < 32) && stall_mask[c]) || (int'($urandom_range(0, 99)) < stall_pct);
         stall     = st;
         {res_sign_in, res_norm_in, res_exp_in} = 19'($urandom);
         @(negedge clk);
         check("run_busy", busy, 1);
         check("run_res_valid", res_valid, 0);
         check("run_pipe_en", pipe_en, !st);
         check("run_rd_en", rd_en, (ns < len) && !st);
         check("run_acc_clr", acc_clr, (ns == 0) && (len > 0) && !st);
         if (rd_en === 1'b1) begin
            if (exp_q.size() == 0) check("rd_addr_unexpected", 1, 0);
            else check("rd_addr", rd_addr, exp_q.pop_front());
         end
         if (st) n_stall++;
         if (ns == len + D - 1) begin
            cap  = {res_sign_in, res_norm_in, res_exp_in};
            done = 1'b1;
         end
         if (!st) ns++;
         if (c > 2000) begin
            check("job_timeout", c, 0);
            done = 1'b1;
         end
      end

`ifdef MAC_SEQ_STALL_CNT_EN
      exp_cnt = (n_stall > 16'hFFFF) ? 16'hFFFF : 16'(n_stall);
`else
      exp_cnt = 16'h0000;
`endif

      for (int i = 0; i <= ready_dly; i++) begin
         @(posedge clk); #1;
         start     = poke_start;
         vec_len   = 8'($urandom_range(1, 255));
         base_addr = 8'($urandom);
         stall     = 1'($urandom_range(0, 1));
         res_ready = (i == ready_dly);
         {res_sign_in, res_norm_in, res_exp_in} = 19'($urandom);
         @(negedge clk);
         check("done_res_valid", res_valid, 1);
         check("done_busy", busy, 1);
         check("done_rd_en", rd_en, 0);
         check("done_pipe_en", pipe_en, 0);
         check("done_acc_clr", acc_clr, 0);
         check("done_result", {res_sign, res_norm, res_exp}, cap);
         check("done_stall_cnt", stall_cnt, exp_cnt);
      end

      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check("post_res_valid", res_valid, 0);
      check("post_busy", busy, 0);
      check("post_state", state_dbg, 0);
      check("post_rd_en", rd_en, 0);
      check("post_pipe_en", pipe_en, 0);
      check("post_result", {res_sign, res_norm, res_exp}, cap);
      check("post_stall_cnt", stall_cnt, exp_cnt);
      check("addr_q_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Reset asserted for one cycle while the job is draining.
   task automatic reset_mid_drain();
      @(posedge clk); #1;
      start = 1'b1; vec_len = 8'd4; base_addr = 8'h10;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("drain_busy", busy, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("mid_rst");
   endtask

   initial begin
      rst = 1'b0;
      drive_idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("after_reset");

      run_job(4, 'h10, 32'h0, 0, 0, 1'b0);
      run_job(4, 'h10, 32'h0000_000C, 0, 0, 1'b0);
      run_job(0, 'h55, 32'h0, 0, 0, 1'b0);
      run_job(3, 'hFE, 32'h0, 0, 0, 1'b0);
      run_job(5, 'h20, 32'h0, 0, 5, 1'b1);
      reset_mid_drain();
      run_job(2, 'h40, 32'h0, 0, 0, 1'b0);

      for (int j = 0; j < 40; j++) begin
         run_job($urandom_range(0, 20), $urandom_range(0, 255), 32'h0,
                 $urandom_range(0, 40), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
